// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-side responder for the EV22 register bank's MR/MW memory commands.
// The sequencer raises MR (read) or MW (write) with an address. This block runs
// the external data-memory handshake and holds busy high until it is finished.
// A completed read places the data on W_IN and pulses w_load for one cycle.
// w_load drives the register bank's MR input, so Working_Reg loads W_IN.
// A write sends the sampled Working_Reg value to memory.
//
// Optional feature, selected by the macro MEM_TIMEOUT_EN:
//   defined   - an ACCESS that sees no mem_ack for TIMEOUT cycles after the
//               wait states expire is aborted. mem_err is set and stays set
//               until reset. An aborted read returns all ones on W_IN and
//               still pulses w_load.
//   undefined - ACCESS waits indefinitely for mem_ack; mem_err is tied to 0.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   nreset       in   synchronous, active-low reset
//   MR / MW      in   read / write request from the sequencer (MR wins a tie)
//   Addr         in   request address, sampled with MR/MW
//   Working_Reg  in   write data, sampled with MW
//   W_IN         out  read data to the register bank
//   w_load       out  one-cycle strobe marking W_IN valid
//   busy         out  access in progress; requests are ignored while high
//   mem_addr     out  address to memory (holds after the access)
//   mem_wdata    out  write data to memory (holds after the access)
//   mem_re       out  read strobe, held until the access completes
//   mem_we       out  write strobe, held until the access completes
//   mem_rdata    in   read data from memory
//   mem_ack      in   memory completion, honoured once the wait states expire
//   mem_err      out  sticky access-timeout flag
//   dbg_state    out  current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//
// Valid/ready handshakes:
//   Sequencer side: a request is accepted only on an edge where the block is
//   IDLE (busy low) and MR or MW is high. A request seen outside IDLE is
//   dropped, not queued. Memory side: mem_re/mem_we act as "valid" and stay
//   high until an edge where the wait counter is zero and mem_ack (the
//   "ready") is high. mem_ack at any other time has no effect.
//
// Every output is driven straight from a register.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_access_unit #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              MR,
    input  logic              MW,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Working_Reg,
    output logic [DATA_W-1:0] W_IN,
    output logic              w_load,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_err,
    output logic [1:0]        dbg_state
);

    // The wait counter must be able to hold WAIT_STATES. It is never narrower
    // than one bit, even when WAIT_STATES is 0.
    localparam int WCNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_is_read;
    logic [DATA_W-1:0]   r_w_in;
    logic                r_w_load;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_re;
    logic                r_mem_we;

    state_t              w_state_nxt;
    logic [WCNT_W-1:0]   w_wcnt_nxt;
    logic                w_is_read_nxt;
    logic [DATA_W-1:0]   w_w_in_nxt;
    logic                w_load_nxt;
    logic                w_busy_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic                w_mem_re_nxt;
    logic                w_mem_we_nxt;

`ifdef MEM_TIMEOUT_EN
    // The timeout counter runs 0 .. TIMEOUT-1 while waiting for an ack. The
    // access is aborted on the edge where it sits at TIMEOUT-1 with no ack.
    localparam int TO_CYC = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam int TCNT_W = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TO_CYC - 1);

    logic [TCNT_W-1:0]   r_tcnt;
    logic                r_err;
    logic [TCNT_W-1:0]   w_tcnt_nxt;
    logic                w_err_nxt;
`endif

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_is_read   <= 1'b0;
            r_w_in      <= '0;
            r_w_load    <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_tcnt      <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_is_read   <= w_is_read_nxt;
            r_w_in      <= w_w_in_nxt;
            r_w_load    <= w_load_nxt;
            r_busy      <= w_busy_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_re    <= w_mem_re_nxt;
            r_mem_we    <= w_mem_we_nxt;
`ifdef MEM_TIMEOUT_EN
            r_tcnt      <= w_tcnt_nxt;
            r_err       <= w_err_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // By default every register holds, except w_load, which is a strobe.
        w_state_nxt     = r_state;
        w_wcnt_nxt      = r_wcnt;
        w_is_read_nxt   = r_is_read;
        w_w_in_nxt      = r_w_in;
        w_load_nxt      = 1'b0;
        w_busy_nxt      = r_busy;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_re_nxt    = r_mem_re;
        w_mem_we_nxt    = r_mem_we;
`ifdef MEM_TIMEOUT_EN
        w_tcnt_nxt      = r_tcnt;
        w_err_nxt       = r_err;
`endif

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                // A read wins over a simultaneous write. The write is
                // dropped silently, so mem_wdata keeps its old value.
                if (MR) begin
                    w_state_nxt    = S_ACCESS;
                    w_mem_addr_nxt = Addr;
                    w_mem_re_nxt   = 1'b1;
                    w_is_read_nxt  = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_wcnt_nxt     = WCNT_LOAD;
`ifdef MEM_TIMEOUT_EN
                    w_tcnt_nxt     = '0;
`endif
                end else if (MW) begin
                    w_state_nxt     = S_ACCESS;
                    w_mem_addr_nxt  = Addr;
                    w_mem_wdata_nxt = Working_Reg;
                    w_mem_we_nxt    = 1'b1;
                    w_is_read_nxt   = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_wcnt_nxt      = WCNT_LOAD;
`ifdef MEM_TIMEOUT_EN
                    w_tcnt_nxt      = '0;
`endif
                end
            end

            S_ACCESS: begin
                if (r_wcnt != '0) begin
                    // Wait states: mem_ack is deliberately ignored here.
                    w_wcnt_nxt = r_wcnt - 1'b1;
                end else if (mem_ack) begin
                    // A normal completion also covers an ack that arrives on
                    // the expiry edge, because this branch is tested first.
                    w_state_nxt  = S_DONE;
                    w_mem_re_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    if (r_is_read) begin
                        w_w_in_nxt = mem_rdata;
                        w_load_nxt = 1'b1;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (r_tcnt == TCNT_LAST) begin
                    w_state_nxt  = S_DONE;
                    w_mem_re_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    w_err_nxt    = 1'b1;
                    if (r_is_read) begin
                        w_w_in_nxt = '1;
                        w_load_nxt = 1'b1;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
`endif
                end
            end

            S_DONE: begin
                // This is the cycle where w_load is high. busy falls on the
                // edge that returns the FSM to IDLE.
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt  = S_IDLE;
                w_busy_nxt   = 1'b0;
                w_mem_re_nxt = 1'b0;
                w_mem_we_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign W_IN      = r_w_in;
    assign w_load    = r_w_load;
    assign busy      = r_busy;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign dbg_state = r_state;

`ifdef MEM_TIMEOUT_EN
    assign mem_err = r_err;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit.
//
// Each access is predicted from its externally visible rules:
//   - the strobe is high for WAIT_STATES + ack_delay + 1 cycles, or for
//     WAIT_STATES + TIMEOUT cycles when the access times out;
//   - busy stays high one cycle longer than the strobe;
//   - a read produces exactly one w_load, and a write produces none;
//   - the address, write data and W_IN hold their values afterwards.
// Read data expected on w_load is queued in exp_q.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_access_unit;

    localparam int WS     = 1;
    localparam int TO     = 4;
    localparam int BUDGET = 64;

    logic        clk;
    logic        nreset;
    logic        MR;
    logic        MW;
    logic [15:0] Addr;
    logic [15:0] Working_Reg;
    logic [15:0] W_IN;
    logic        w_load;
    logic        busy;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the held outputs
    logic [15:0] m_w_in  = '0;
    logic [15:0] m_addr  = '0;
    logic [15:0] m_wdata = '0;
    logic        m_err   = 1'b0;
    logic [15:0] exp_q[$];

    mem_access_unit #(
        .ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .nreset(nreset), .MR(MR), .MW(MW), .Addr(Addr),
        .Working_Reg(Working_Reg), .W_IN(W_IN), .w_load(w_load), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_err(mem_err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w_in"},   W_IN, 0);
        check({tag, "_w_load"}, w_load, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_addr"},   mem_addr, 0);
        check({tag, "_wdata"},  mem_wdata, 0);
        check({tag, "_re"},     mem_re, 0);
        check({tag, "_we"},     mem_we, 0);
        check({tag, "_err"},    mem_err, 0);
    endtask

    task automatic model_reset();
        m_w_in  = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver: one complete access ----------------
    // rd/wr: request lines. ign: pulse MR again while busy. early: ack during
    // wait states. noack: never ack (timeout). d: extra cycles before ack.
    task automatic run_access(input bit rd, input bit wr, input bit ign, input bit early,
                              input bit noack, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] rdata,
                              input int d);
        int n_re, n_we, n_busy, n_wl, exp_n;
        bit done, is_rd, is_wr;
        is_rd = rd;
        is_wr = wr && !rd;
        exp_n = noack ? (WS + TO) : (WS + d + 1);
        if (is_rd) exp_q.push_back(noack ? 16'hFFFF : rdata);

        @(negedge clk);
        MR = rd; MW = wr; Addr = addr; Working_Reg = wdata; mem_rdata = rdata;
        @(posedge clk);
        n_re = 0; n_we = 0; n_busy = 0; n_wl = 0; done = 0;
        for (int k = 0; k < BUDGET && !done; k++) begin
            @(negedge clk);
            MR = ign && (k == 1);
            MW = 1'b0;
            Addr = 16'($urandom);
            Working_Reg = 16'($urandom);
            if (k == 0) check("addr_latch", mem_addr, addr);
            if (mem_re) n_re++;
            if (mem_we) n_we++;
            if (busy) n_busy++;
            if (w_load) begin
                n_wl++;
                if (exp_q.size() > 0) check("w_in_on_load", W_IN, exp_q.pop_front());
                else check("spurious_w_load", w_load, 0);
            end
            mem_ack = (mem_re || mem_we) &&
                      ((!noack && k >= WS + d) || (early && k < WS));
            if (!busy) done = 1;
        end
        mem_ack = 1'b0;
        check("access_done", done, 1);
        check("re_cycles", n_re, is_rd ? exp_n : 0);
        check("we_cycles", n_we, is_wr ? exp_n : 0);
        check("busy_cycles", n_busy, exp_n + 1);
        check("w_load_count", n_wl, is_rd ? 1 : 0);

        m_addr = addr;
        if (is_wr) m_wdata = wdata;
        if (is_rd) m_w_in = noack ? 16'hFFFF : rdata;
        if (noack) m_err = 1'b1;

        check("addr_hold", mem_addr, m_addr);
        check("wdata_hold", mem_wdata, m_wdata);
        check("w_in_hold", W_IN, m_w_in);
        check("err_flag", mem_err, m_err);
        check("queue_empty", exp_q.size(), 0);

        // No second access may follow, even if MR was pulsed while busy.
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_strobe", mem_re | mem_we, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        check_all_zero("reset_pulse");
        nreset = 1'b1;
        model_reset();
    endtask

    // A read that is cut short by reset while it waits for an ack.
    task automatic mid_access_reset(input logic [15:0] addr);
        @(negedge clk);
        MR = 1'b1; Addr = addr; mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        MR = 1'b0;
        check("mid_pre_re", mem_re, 1);
        @(negedge clk);
        nreset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        nreset = 1'b1;
        mem_ack = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_no_wload", w_load, 0);
            check("mid_no_strobe", mem_re | mem_we, 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        nreset = 1'b0; MR = 1'b1; MW = 1'b0; Addr = 16'h00AA;
        Working_Reg = 16'h5555; mem_rdata = 16'h0; mem_ack = 1'b1;

        // Reset held for two cycles while a request and an ack are present
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        MR = 1'b0; mem_ack = 1'b0;
        nreset = 1'b1;
        model_reset();

        // Directed cases
        run_access(1, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'hBEEF, 0); // read, immediate ack
        run_access(0, 1, 0, 0, 0, 16'h0007, 16'h1234, 16'h0000, 3); // write, ack late
        run_access(1, 1, 0, 0, 0, 16'h0010, 16'hAAAA, 16'h0F0F, 1); // collision
        run_access(1, 0, 1, 0, 0, 16'h0020, 16'h0000, 16'hC0DE, 2); // MR pulsed while busy
        run_access(1, 0, 0, 1, 0, 16'h0030, 16'h0000, 16'h7777, 0); // early ack ignored
        run_access(0, 1, 0, 1, 0, 16'h0031, 16'h9999, 16'h0000, 1); // early ack on a write
        mid_access_reset(16'h0055);
        run_access(1, 0, 0, 0, 0, 16'h0056, 16'h0000, 16'h4242, 0); // clean read after reset

        // Randomised accesses
        for (int n = 0; n < 30; n++) begin
            int op;
            op = $urandom_range(0, 2);
            run_access(op != 1, op != 0, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b0,
                       16'($urandom), 16'($urandom), 16'($urandom),
                       $urandom_range(0, 4));
        end

`ifdef MEM_TIMEOUT_EN
        run_access(1, 0, 0, 0, 0, 16'h0100, 16'h0000, 16'h1111, TO - 1); // ack on expiry edge
        run_access(1, 0, 0, 0, 1, 16'h0101, 16'h0000, 16'h2222, 0);      // read timeout
        run_access(0, 1, 0, 0, 1, 16'h0102, 16'h3333, 16'h0000, 0);      // write timeout
        run_access(1, 0, 0, 0, 0, 16'h0103, 16'h0000, 16'h4444, 1);      // error stays sticky
        pulse_reset();
        check("err_cleared", mem_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Overall time bound on the run
    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
